// File: rtl/stopwatch_time_core.sv
// -----------------------------------------------------------------------------
// stopwatch_time_core
//
// Accumulates elapsed time as BCD MM:SS from the divider tick. Start/stop,
// clear and lap (display freeze) controls are 1-cycle pulses. Only the
// highest-priority control acts in a cycle: clear > start_stop > lap.
//
// Parameters:
//   TICKS_PER_INCREMENT  tick_in pulses per 1-second increment (>= 1)
//   MAX_MINUTES          highest minute value before wrapping to 00:00 (1..99)
//
// Ports:
//   clk         board clock
//   rst         asynchronous, active-high reset
//   tick_in     1-cycle divider pulse; counted only in RUN or LAP
//   start_stop  1-cycle pulse; toggles run/pause
//   clear       1-cycle pulse; zero time and overflow, go idle
//   lap         1-cycle pulse; freeze/release displayed value while running
//   sec_ones    displayed seconds units (BCD 0-9)
//   sec_tens    displayed seconds tens (BCD 0-5)
//   min_ones    displayed minutes units (BCD 0-9)
//   min_tens    displayed minutes tens (BCD 0-9)
//   running     high in RUN or LAP
//   lap_active  high in LAP
//   overflow    sticky; set on the MAX_MINUTES:59 -> 00:00 wrap
// -----------------------------------------------------------------------------
module stopwatch_time_core #(
  parameter int TICKS_PER_INCREMENT = 1,
  parameter int MAX_MINUTES         = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    LAP
  } state_t;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  localparam int              PS_W         = (TICKS_PER_INCREMENT > 1) ?
                                             $clog2(TICKS_PER_INCREMENT) : 1;
  localparam logic [PS_W-1:0] PS_LAST      = PS_W'(TICKS_PER_INCREMENT - 1);
  localparam logic [3:0]      MAX_MIN_TENS = 4'(MAX_MINUTES / 10);
  localparam logic [3:0]      MAX_MIN_ONES = 4'(MAX_MINUTES % 10);

  state_t          state_q;
  bcd_time_t       time_q, time_d;
  bcd_time_t       snap_q;
  bcd_time_t       disp;
  logic [PS_W-1:0] presc_q, presc_d;
  logic            overflow_q;
  logic            count_tick;
  logic            second_tick;
  logic            wrap;

  // Next live time and prescaler. Ticks are judged against the pre-edge
  // state, so a tick arriving with start_stop in RUN still counts, while one
  // arriving with start_stop in PAUSE/IDLE does not.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    count_tick  = tick_in && ((state_q == RUN) || (state_q == LAP));
    second_tick = count_tick && (presc_q == PS_LAST);
    wrap        = (time_q.min_tens == MAX_MIN_TENS) &&
                  (time_q.min_ones == MAX_MIN_ONES) &&
                  (time_q.sec_tens == 4'd5) &&
                  (time_q.sec_ones == 4'd9);
    presc_d     = presc_q;
    time_d      = time_q;

    if (count_tick) begin
      presc_d = second_tick ? '0 : presc_q + 1'b1;
    end

    // Cascaded BCD carries all resolve on the same edge.
    if (second_tick) begin
      if (wrap) begin
        time_d = '0;
      end else if (time_q.sec_ones != 4'd9) begin
        time_d.sec_ones = time_q.sec_ones + 4'd1;
      end else begin
        time_d.sec_ones = 4'd0;
        if (time_q.sec_tens != 4'd5) begin
          time_d.sec_tens = time_q.sec_tens + 4'd1;
        end else begin
          time_d.sec_tens = 4'd0;
          if (time_q.min_ones != 4'd9) begin
            time_d.min_ones = time_q.min_ones + 4'd1;
          end else begin
            time_d.min_ones = 4'd0;
            time_d.min_tens = time_q.min_tens + 4'd1;
          end
        end
      end
    end
  end

  // Control FSM plus time, snapshot, prescaler and overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the lap snapshot relies on this to capture
    // the pre-increment time when a tick lands on the same edge.
    if (rst) begin
      state_q    <= IDLE;
      time_q     <= '0;
      snap_q     <= '0;
      presc_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      state_q    <= IDLE;
      time_q     <= '0;
      snap_q     <= '0;
      presc_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      time_q  <= time_d;
      presc_q <= presc_d;
      if (second_tick && wrap) begin
        overflow_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (start_stop) state_q <= RUN;
        end
        RUN: begin
          if (start_stop) begin
            state_q <= PAUSE;
          end else if (lap) begin
            state_q <= LAP;
            snap_q  <= time_q;
          end
        end
        LAP: begin
          if (start_stop) begin
            state_q <= PAUSE;
          end else if (lap) begin
            state_q <= RUN;
          end
        end
        PAUSE: begin
          if (start_stop) state_q <= RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Display mux straight off the registers: no extra pipeline latency.
  assign disp       = (state_q == LAP) ? snap_q : time_q;
  assign sec_ones   = disp.sec_ones;
  assign sec_tens   = disp.sec_tens;
  assign min_ones   = disp.min_ones;
  assign min_tens   = disp.min_tens;
  assign running    = (state_q == RUN) || (state_q == LAP);
  assign lap_active = (state_q == LAP);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_time_core.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_time_core
//
// Two instances share the control inputs: dut_a (1 tick per second) and
// dut_b (10 ticks per second). Expected output words are
// {min_tens, min_ones, sec_tens, sec_ones, running, lap_active, overflow},
// so the digit part reads as MMSS in hex.
// -----------------------------------------------------------------------------
module tb_stopwatch_time_core;

  logic clk = 1'b0;
  logic rst;
  logic tick_in, start_stop, clear, lap;

  logic [3:0] a_so, a_st, a_mo, a_mt, b_so, b_st, b_mo, b_mt;
  logic       a_run, a_lap, a_ovf, b_run, b_lap, b_ovf;
  logic [18:0] obs_a, obs_b;

  always #5 clk = ~clk;

  stopwatch_time_core #(.TICKS_PER_INCREMENT(1), .MAX_MINUTES(59)) dut_a (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
    .clear(clear), .lap(lap),
    .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo), .min_tens(a_mt),
    .running(a_run), .lap_active(a_lap), .overflow(a_ovf)
  );

  stopwatch_time_core #(.TICKS_PER_INCREMENT(10), .MAX_MINUTES(59)) dut_b (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
    .clear(clear), .lap(lap),
    .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo), .min_tens(b_mt),
    .running(b_run), .lap_active(b_lap), .overflow(b_ovf)
  );

  assign obs_a = {a_mt, a_mo, a_st, a_so, a_run, a_lap, a_ovf};
  assign obs_b = {b_mt, b_mo, b_st, b_so, b_run, b_lap, b_ovf};

  // ctl = {tick_in, start_stop, clear, lap}; flags = {running, lap_active, overflow}
  typedef struct packed {
    logic [3:0]  ctl;
    logic [15:0] digits;
    logic [2:0]  flags;
  } vec_t;

  typedef struct {
    bit          sel;
    logic [18:0] expv;
  } sb_t;

  sb_t   sb_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    secs  = 0;
  logic  ovf_m = 1'b0;

  task automatic check(input string name, input logic [18:0] act,
                       input logic [18:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h (MMSS=%h r/l/o=%b) want %h (MMSS=%h r/l/o=%b)",
               name, act, act[18:3], act[2:0], expv, expv[18:3], expv[2:0]);
    end
  endtask

  // Drive one cycle of controls; optionally queue the expectation, which is
  // popped and compared once the DUT has taken the edge.
  task automatic step(input logic [3:0] ctl, input bit chk, input bit sel,
                      input logic [18:0] expv, input string name);
    sb_t e;
    {tick_in, start_stop, clear, lap} = ctl;
    if (chk) begin
      e.sel  = sel;
      e.expv = expv;
      sb_q.push_back(e);
      name_q.push_back(name);
    end
    @(posedge clk);
    #1;
    {tick_in, start_stop, clear, lap} = 4'b0000;
    if (sb_q.size() > 0) begin
      string nm;
      e  = sb_q.pop_front();
      nm = name_q.pop_front();
      check(nm, e.sel ? obs_b : obs_a, e.expv);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  // Model-checked ticks on dut_a while running (not in LAP).
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      secs++;
      if (secs == 3600) begin
        secs  = 0;
        ovf_m = 1'b1;
      end
      step(4'b1000, 1'b1, 1'b0, {to_bcd(secs), 1'b1, 1'b0, ovf_m},
           $sformatf("tick_to_%0d", secs));
    end
  endtask

  task automatic blind_ticks(input int n);
    for (int i = 0; i < n; i++) step(4'b1000, 1'b0, 1'b0, '0, "");
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{4'b0000, 16'h0000, 3'b000};  // idle after reset
    vecs[1]  = '{4'b0001, 16'h0000, 3'b000};  // lap ignored in IDLE
    vecs[2]  = '{4'b1000, 16'h0000, 3'b000};  // tick ignored in IDLE
    vecs[3]  = '{4'b0100, 16'h0000, 3'b100};  // start -> RUN
    vecs[4]  = '{4'b1000, 16'h0001, 3'b100};
    vecs[5]  = '{4'b1100, 16'h0002, 3'b000};  // tick+ss in RUN: counted, PAUSE
    vecs[6]  = '{4'b1000, 16'h0002, 3'b000};  // tick in PAUSE ignored
    vecs[7]  = '{4'b1100, 16'h0002, 3'b100};  // tick+ss in PAUSE: not counted
    vecs[8]  = '{4'b1001, 16'h0002, 3'b110};  // tick+lap: snapshot pre-increment
    vecs[9]  = '{4'b1000, 16'h0002, 3'b110};  // display frozen
    vecs[10] = '{4'b0001, 16'h0004, 3'b100};  // lap release shows live
    vecs[11] = '{4'b0001, 16'h0004, 3'b110};
    vecs[12] = '{4'b1100, 16'h0005, 3'b000};  // tick+ss in LAP: counted, PAUSE
    vecs[13] = '{4'b0101, 16'h0005, 3'b100};  // ss beats lap
    vecs[14] = '{4'b1110, 16'h0000, 3'b000};  // clear beats all, tick dropped
    vecs[15] = '{4'b0100, 16'h0000, 3'b100};

    rst = 1'b1;
    {tick_in, start_stop, clear, lap} = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs_a, 19'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].ctl, 1'b1, 1'b0, {vecs[i].digits, vecs[i].flags},
           $sformatf("vec%0d", i));
    end

    // Full count through all carries to the 59:59 -> 00:00 wrap.
    step(4'b0010, 1'b1, 1'b0, {16'h0000, 3'b000}, "clear_a");
    step(4'b0100, 1'b1, 1'b0, {16'h0000, 3'b100}, "start_a");
    secs  = 0;
    ovf_m = 1'b0;
    run_ticks(75);
    check("at_01_15", obs_a, {16'h0115, 3'b100});
    run_ticks(3599 - 75);
    check("at_59_59", obs_a, {16'h5959, 3'b100});
    run_ticks(1);
    check("wrap_00_00", obs_a, {16'h0000, 3'b101});
    run_ticks(3);
    step(4'b0010, 1'b1, 1'b0, {16'h0000, 3'b000}, "clear_ovf");

    // Lap freeze and release.
    step(4'b0100, 1'b1, 1'b0, {16'h0000, 3'b100}, "start_lap");
    secs  = 0;
    ovf_m = 1'b0;
    run_ticks(10);
    step(4'b0001, 1'b1, 1'b0, {16'h0010, 3'b110}, "lap_on");
    for (int i = 0; i < 5; i++) begin
      step(4'b1000, 1'b1, 1'b0, {16'h0010, 3'b110}, $sformatf("lap_hold%0d", i));
    end
    step(4'b0001, 1'b1, 1'b0, {16'h0015, 3'b100}, "lap_off");
    step(4'b1000, 1'b1, 1'b0, {16'h0016, 3'b100}, "after_lap");

    // Prescaler on dut_b survives a pause.
    step(4'b0010, 1'b1, 1'b1, {16'h0000, 3'b000}, "b_clear");
    step(4'b0100, 1'b1, 1'b1, {16'h0000, 3'b100}, "b_start");
    blind_ticks(24);
    step(4'b1000, 1'b1, 1'b1, {16'h0002, 3'b100}, "b_25_ticks");
    step(4'b0100, 1'b1, 1'b1, {16'h0002, 3'b000}, "b_pause");
    blind_ticks(9);
    step(4'b1000, 1'b1, 1'b1, {16'h0002, 3'b000}, "b_paused_ticks");
    step(4'b0100, 1'b1, 1'b1, {16'h0002, 3'b100}, "b_resume");
    blind_ticks(3);
    step(4'b1000, 1'b1, 1'b1, {16'h0002, 3'b100}, "b_4_ticks");
    step(4'b1000, 1'b1, 1'b1, {16'h0003, 3'b100}, "b_5th_tick");

    // Async reset mid-count at 03:27.
    step(4'b0010, 1'b1, 1'b0, {16'h0000, 3'b000}, "clear_rst");
    step(4'b0100, 1'b1, 1'b0, {16'h0000, 3'b100}, "start_rst");
    secs  = 0;
    ovf_m = 1'b0;
    run_ticks(207);
    check("at_03_27", obs_a, {16'h0327, 3'b100});
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_a", obs_a, 19'h0);
    check("async_rst_b", obs_b, 19'h0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b1000, 1'b1, 1'b0, {16'h0000, 3'b000}, "post_rst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_time_core.md
Name: stopwatch_time_core

Overview:
- Consumer end of the divider tick interface: accepts the 1-cycle threshold pulse from the clock divider and accumulates elapsed time as BCD MM:SS.
- Adds start/stop, clear and lap (display freeze) control.
- Sits between the tick generator and the 7-segment display driver.
- Outputs are BCD digits ready for the display mux.

Parameters:
- TICKS_PER_INCREMENT, 1, number of tick_in pulses per 1-second increment (>=1); lets a faster divider tick drive the core.
- MAX_MINUTES, 59, highest minute value before rollover (1..99).

Ports:
- clk  input  1  board clock
- rst  input  1  asynchronous, active-high reset
- tick_in  input  1  1-cycle pulse from divider; counts only while running
- start_stop  input  1  1-cycle pulse (debounced/edge-detected upstream); toggles run/pause
- clear  input  1  1-cycle pulse; zero time, go idle
- lap  input  1  1-cycle pulse; freeze/release displayed value while running
- sec_ones  output  4  displayed seconds units BCD 0-9
- sec_tens  output  4  displayed seconds tens BCD 0-5
- min_ones  output  4  displayed minutes units BCD 0-9
- min_tens  output  4  displayed minutes tens BCD 0-9
- running  output  1  high in RUN or LAP
- lap_active  output  1  high in LAP
- overflow  output  1  sticky; set on MAX_MINUTES:59 -> 00:00 wrap

Behaviour:
- Reset (async, rst=1): state IDLE; live time, snapshot and prescaler = 0; all digit outputs 0; running=0, lap_active=0, overflow=0.
- FSM states: IDLE, RUN, PAUSE, LAP.
- Control priority per cycle: clear > start_stop > lap. Only the highest-priority asserted control acts.
- clear, any state: -> IDLE; live time, snapshot and prescaler = 0; overflow=0.
- IDLE: start_stop -> RUN; lap ignored.
- RUN: start_stop -> PAUSE; lap -> LAP and capture live time into snapshot.
- LAP: start_stop -> PAUSE (display reverts to live); lap -> RUN (display reverts to live).
- PAUSE: start_stop -> RUN; lap ignored. Prescaler and time retained.
- Tick counting: tick_in is counted when the current (pre-edge) state is RUN or LAP.
  - Counted tick with prescaler < TICKS_PER_INCREMENT-1: prescaler+1, no time change.
  - Counted tick with prescaler = TICKS_PER_INCREMENT-1: prescaler=0, time +1 s.
  - With TICKS_PER_INCREMENT=1, every counted tick increments time.
- Simultaneous events:
  - tick_in + start_stop in RUN: tick counted and state -> PAUSE on the same edge.
  - tick_in + start_stop in PAUSE/IDLE: tick not counted; state -> RUN.
  - tick_in + clear: clear wins; tick dropped.
  - tick_in + lap in RUN: the snapshot captures the pre-increment time; live time increments.
- BCD arithmetic, cascaded carries on the same edge:
  - sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into minutes.
  - min_ones 9->0 carries into min_tens.
  - At MAX_MINUTES:59 an increment yields 00:00 and sets overflow; counting continues.
  - Digits never hold non-BCD values.
- Display: digit outputs are a combinational mux of registered values, so there is no added pipeline latency.
  - LAP shows the snapshot; all other states show live time.
  - New time is visible on outputs immediately after the edge that samples tick_in=1.
- running and lap_active decode directly from the state register.
- Async reset mid-count returns everything to reset values immediately; no partial state is retained.

Test Plan:
- Reset, start_stop, then 75 ticks (TICKS_PER_INCREMENT=1) -> outputs 01:15, running=1, overflow=0.
- Run to 00:59, one tick -> 01:00 on the next edge. Run to 09:59, one tick -> 10:00 (sec and min_ones carries in one edge).
- MAX_MINUTES=59, preload to 59:59 by ticking, one tick -> 00:00, overflow=1 and stays 1. clear -> overflow=0, IDLE, 00:00.
- At 00:10 pulse lap; 5 more ticks -> display holds 00:10, lap_active=1. lap again -> display 00:15, state RUN.
- TICKS_PER_INCREMENT=10: 25 ticks in RUN -> 00:02. start_stop (PAUSE), 10 ticks -> still 00:02. start_stop, 5 ticks -> 00:03, because the prescaler value is preserved across the pause.
- Same-cycle events:
  - tick+start_stop in RUN at 00:04 -> 00:05, PAUSE.
  - tick+clear -> 00:00, IDLE.
  - rst asserted mid-count at 03:27 -> all outputs 0 without waiting for a clk edge.
